irq_ctrl_n: RTL

Parametrised interrupt controller, successor to the fixed five-source DMG interrupt block. It generalises the source count, adds an on-chip enable register, and adds a priority encoder with a registered request/acknowledge handshake toward the CPU core. A keypad press-detect channel with a configurable debounce chain is optional. It sits between the peripheral interrupt sources and the CPU core, on the FF0F/FFFF register strobes.

---
 rtl/irq_ctrl_n.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl_n.sv
// rtl/irq_ctrl_n.sv - parametrised interrupt controller with priority request/ack handshake
//
// Purpose: latches rising edges of irq_in into IF, masks with IE, and presents the
// lowest-index pending channel to the CPU through a registered irq_req/irq_vec pair
// that is held until irq_ack or until software removes the pending condition.
// Optional feature macro: IRQ_CTRL_KEYPAD_EN (keypad press-detect on channel KEY_CH
// through a DEBOUNCE_STAGES-deep chain; wake = |key_in). Without it key_in is unused
// and wake is 0.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   irq_in[NUM_IRQ]     level interrupt sources, rising-edge sensitive
//   key_in[4]           raw keypad column lines (keypad build only)
//   if_wr/if_rd         IF register write/read strobes
//   ie_wr/ie_rd         IE register write/read strobes
//   wdata[8]/rdata[8]   register write data / combinational read data (FF when idle)
//   irq_req/irq_vec[3]  request and channel index toward the CPU
//   irq_ack             one-cycle acknowledge from the CPU
//   wake                stop-mode wake (|key_in in keypad build)

module irq_ctrl_n #(
    parameter int NUM_IRQ         = 5,
    parameter int KEY_CH          = 4,
    parameter int DEBOUNCE_STAGES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [3:0]         key_in,
    input  logic               if_wr,
    input  logic               if_rd,
    input  logic               ie_wr,
    input  logic               ie_rd,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               irq_req,
    output logic [2:0]         irq_vec,
    input  logic               irq_ack,
    output logic               wake
);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] ie_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] set_vec;
    logic [NUM_IRQ-1:0] if_next;
    logic [7:0]         pend8;
    logic [7:0]         ack8;
    logic [2:0]         winner;

`ifdef IRQ_CTRL_KEYPAD_EN
    // key_any acts as stage 0 of the chain; stages 1..N-1 are registered, so a press
    // sampled at clock k reaches the last stage in time to fire at k+N-1.
    logic                         key_any;
    logic [DEBOUNCE_STAGES-1:1]   key_sr;
    logic                         key_last_prev;
    logic                         key_set;

    assign key_any = |key_in;
    assign wake    = key_any;
    assign key_set = key_any & key_sr[DEBOUNCE_STAGES-1] & ~key_last_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_sr        <= '0;
            key_last_prev <= 1'b0;
        end else begin
            key_sr[1] <= key_any;
            for (int i = 2; i < DEBOUNCE_STAGES; i++) begin
                key_sr[i] <= key_sr[i-1];
            end
            key_last_prev <= key_sr[DEBOUNCE_STAGES-1];
        end
    end
`else
    logic unused_key;
    assign unused_key = ^key_in;
    assign wake       = 1'b0;
`endif

    always_comb begin
        set_vec = irq_in & ~prev_q;
`ifdef IRQ_CTRL_KEYPAD_EN
        set_vec[KEY_CH] = key_set;
`endif
    end

    // Only the channel currently being presented can be acknowledged.
    always_comb begin
        ack8 = 8'h00;
        if (state == ST_REQ && irq_ack) begin
            ack8[irq_vec] = 1'b1;
        end
    end

    // A new edge beats any clear, so an edge coinciding with its own ack is not lost.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (set_vec[i]) begin
                if_next[i] = 1'b1;
            end else if (ack8[i] || (if_wr && !wdata[i])) begin
                if_next[i] = 1'b0;
            end else if (if_wr) begin
                if_next[i] = 1'b1;
            end else begin
                if_next[i] = if_q[i];
            end
        end
    end

    always_comb begin
        pend8              = 8'h00;
        pend8[NUM_IRQ-1:0] = if_q & ie_q;
    end

    always_comb begin
        winner = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend8[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_comb begin
        rdata = 8'hFF;
        if (if_rd) begin
            rdata[NUM_IRQ-1:0] = if_q;
        end else if (ie_rd) begin
            rdata[NUM_IRQ-1:0] = ie_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_q   <= '0;
            ie_q   <= '0;
            prev_q <= '0;
        end else begin
            if_q   <= if_next;
            prev_q <= irq_in;
            if (ie_wr) begin
                ie_q <= wdata[NUM_IRQ-1:0];
            end
        end
    end

    // Once in REQ the vector is frozen; a higher-priority arrival waits for the
    // current request to be acked or withdrawn.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
            irq_vec <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend8 != 8'h00) begin
                        irq_vec <= winner;
                        irq_req <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (irq_ack || !pend8[irq_vec]) begin
                        irq_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    irq_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
